// File: rtl/flow_combiner_t.sv
// flow_combiner_t: buffers {flow_0, flow_1} pairs and re-serializes them as flow_0 then flow_1.
module flow_combiner_t #(
   parameter int BITS_BLOCK = 257,
   parameter int PAIR_DEPTH = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [BITS_BLOCK-1:0] flow_0,
   input  logic [BITS_BLOCK-1:0] flow_1,
   output logic [BITS_BLOCK-1:0] output_blocks,
   output logic                  valid,
   input  logic                  i_ready,
   output logic [CNT_WIDTH-1:0]  block_cnt,
   output logic                  ovf_err
);
   localparam int AW = $clog2(PAIR_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(PAIR_DEPTH);
   logic [BITS_BLOCK-1:0] f0_q [PAIR_DEPTH];
   logic [BITS_BLOCK-1:0] f1_q [PAIR_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
   logic phase_q, phase_d, ovf_q, ovf_d, push, hs, pop;
   assign o_ready       = cnt_q < FULL;
   assign valid         = cnt_q != '0;
   assign output_blocks = phase_q ? f1_q[rd_q] : f0_q[rd_q];
   assign block_cnt     = bcnt_q;
   assign ovf_err       = ovf_q;
   // A pair leaves the FIFO only once its flow_1 half is accepted.
   always_comb begin
      push    = i_valid && o_ready;
      hs      = valid && i_ready;
      pop     = hs && phase_q;
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      phase_d = hs ? !phase_q : phase_q;
      bcnt_d  = hs ? bcnt_q + 1'b1 : bcnt_q;
      ovf_d   = ovf_q || (i_valid && !o_ready);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         bcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         bcnt_q  <= bcnt_d;
         ovf_q   <= ovf_d;
         if (push) begin
            f0_q[wr_q] <= flow_0;
            f1_q[wr_q] <= flow_1;
         end
      end
   end
endmodule

// File: doc/flow_combiner_t.md
Name: flow_combiner_t

Overview:
- Transmit-side counterpart of the two-flow receive distributor.
- Accepts pairs of 257-bit blocks (flow_0, flow_1) and re-serializes them into one block stream in the order flow_0 then flow_1.
- Buffers up to PAIR_DEPTH pairs, so the output can run at one block per clock while the input delivers one pair every two clocks.
- Uses valid/ready handshakes on both sides and keeps a wrapping count of blocks sent.

Parameters:
BITS_BLOCK  257  width of one block
PAIR_DEPTH  2  pair FIFO depth in pairs; power of two, minimum 2
CNT_WIDTH  32  width of the output block counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_valid  input  1  flow_0/flow_1 hold a valid pair
o_ready  output  1  combiner can accept a pair this cycle
flow_0  input  BITS_BLOCK  first block of the pair; sent first
flow_1  input  BITS_BLOCK  second block of the pair; sent second
output_blocks  output  BITS_BLOCK  serialized block
valid  output  1  output_blocks is valid
i_ready  input  1  downstream accepts output_blocks this cycle
block_cnt  output  CNT_WIDTH  number of blocks accepted downstream; wraps
ovf_err  output  1  sticky: i_valid was asserted while o_ready was low

Behaviour:
- One clock. Synchronous active-high reset. Single always_ff for state, nonblocking assignments.
- State:
  - pair FIFO: PAIR_DEPTH entries of {flow_0, flow_1}
  - wr_ptr and rd_ptr, each log2(PAIR_DEPTH) bits
  - count, 0..PAIR_DEPTH
  - phase bit: 0 = send the flow_0 half of the head pair, 1 = send the flow_1 half
  - block_cnt and ovf_err
- Reset: count=0, pointers=0, phase=0, block_cnt=0, ovf_err=0. As a result valid=0 and o_ready=1 in the first cycle after reset. FIFO data is not cleared, and output_blocks is don't-care while valid=0. Reset takes priority over every other event.
- Reset mid-operation: any buffered pairs, including a pair whose flow_0 half was already sent, are discarded. The first pair written after reset always starts with phase=0.
- o_ready = (count < PAIR_DEPTH), combinational from registered state only. It never depends on i_ready, so there is no combinational path from input to output.
- valid = (count != 0).
- output_blocks = phase ? head.flow_1 : head.flow_0, a combinational mux from the FIFO head.
- Push: on i_valid && o_ready, write {flow_0, flow_1} at wr_ptr, wr_ptr+1 (wraps), count+1.
- Output handshake: on valid && i_ready:
  - if phase=0, set phase=1;
  - if phase=1, set phase=0, rd_ptr+1 (wraps), count-1 (pop).
  - In both cases block_cnt+1, wrapping at 2^CNT_WIDTH.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: while count=PAIR_DEPTH, o_ready=0 and the input is ignored. If i_valid=1 in that cycle, ovf_err is set and stays set until reset. A pop in the same cycle does not make that cycle's push legal.
- Empty: valid=0 and i_ready is ignored, so block_cnt and phase do not change.
- Latency: a pair accepted at edge N, into an empty FIFO, shows flow_0 on output_blocks with valid=1 in the cycle after edge N. flow_1 follows in the cycle after the first output handshake.
- Stall: while i_ready=0 with valid=1, output_blocks, valid and phase hold exactly.
- Throughput: with i_ready held at 1 and a pair offered every 2 cycles, the output is back-to-back with no bubble. This is also true at PAIR_DEPTH=2.
- Ordering: output order is strictly pair order, and within each pair flow_0 precedes flow_1. No block is dropped or duplicated.

Test Plan:
1. Reset then a single pair, flow_0=0x1, flow_1=0x2, i_ready=1 → valid=1 with output 0x1 in the next cycle, 0x2 in the cycle after, then valid=0; block_cnt=2; o_ready stays 1.
2. Stream of 8 pairs (0x10+2k, 0x11+2k) at one pair per 2 cycles, i_ready=1 → 16 consecutive output cycles carrying 0x10..0x1F with no gap; block_cnt=16; ovf_err=0.
3. Backpressure: i_ready=0, push 2 pairs (A,B), (C,D) → o_ready=0 after the second push and output holds A. A third i_valid then sets ovf_err=1. Release i_ready → output A,B,C,D; ovf_err stays 1.
4. Stall mid-pair: after A is accepted, drop i_ready for 3 cycles → output holds B with valid=1 for 3 cycles; B is sent once when i_ready returns.
5. Full with simultaneous pop: FIFO full with phase=1 and i_ready=1 while i_valid=1 → pop occurs, the push is rejected (o_ready was 0), ovf_err=1, count=PAIR_DEPTH-1.
6. Reset after A is sent but before B is sent → valid=0 and block_cnt=0 next cycle. A new pair (E,F) then outputs E first; B is never emitted. Separately, with CNT_WIDTH=4, 16 output blocks wrap block_cnt back to 0.
